// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO input conditioning path: default debounce timing
// and the counter-width helper used by the prescaler and per-pin counters.
package gpio_pkg;

    localparam int DEFAULT_TICK_DIV       = 1000;
    localparam int DEFAULT_DEBOUNCE_TICKS = 4;

    typedef enum logic {
        PIN_MATCH,
        PIN_PENDING
    } pin_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // Counters need at least one bit even when they only ever hold zero.
    function automatic int cnt_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/gpio_debounce_pin.sv
// One pin of the conditioner: synchronizer chain, tick-based debounce counter,
// registered stable level and rise/fall detection.
module gpio_debounce_pin
    import gpio_pkg::*;
#(
    parameter int   SYNC_STAGES    = 2,
    parameter int   DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
    parameter logic RESET_VALUE    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic pin_raw,
    input  logic bypass,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int            CW       = cnt_width(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   stable_q, stable_d, stable_prev_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    pin_state_e             state;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign state    = (sync_out == stable_q) ? PIN_MATCH : PIN_PENDING;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (bypass) begin
            stable_d = sync_out;
            cnt_d    = '0;
        end else begin
            case (state)
                PIN_MATCH: cnt_d = '0;
                PIN_PENDING: begin
                    if (tick) begin
                        if (cnt_q == CNT_LAST) begin
                            stable_d = sync_out;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= {SYNC_STAGES{RESET_VALUE}};
            stable_q      <= RESET_VALUE;
            stable_prev_q <= RESET_VALUE;
            cnt_q         <= '0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], pin_raw};
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    // Edge pulses line up with the first cycle of the new level.
    assign level = stable_q;
    assign rise  = stable_q & ~stable_prev_q;
    assign fall  = ~stable_q & stable_prev_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO bank input conditioner: shared debounce prescaler plus WIDTH independent
// synchronize/debounce/edge-detect pin slices.
module gpio_input_conditioner
    import gpio_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter int               SYNC_STAGES    = 2,
    parameter int               TICK_DIV       = DEFAULT_TICK_DIV,
    parameter int               DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
    input  logic             io_clock,
    input  logic             io_reset,
    input  logic [WIDTH-1:0] io_pins_raw,
    input  logic [WIDTH-1:0] io_bypass,
    output logic [WIDTH-1:0] io_pins_read,
    output logic [WIDTH-1:0] io_rise,
    output logic [WIDTH-1:0] io_fall
);

    localparam int            PW       = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q;
    logic          tick;

    assign tick = (pre_q == PRE_LAST);

    always_ff @(posedge io_clock) begin
        if (io_reset)  pre_q <= '0;
        else if (tick) pre_q <= '0;
        else           pre_q <= pre_q + 1'b1;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_debounce_pin #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .RESET_VALUE   (RESET_VALUE[i])
        ) u_pin (
            .clk    (io_clock),
            .rst    (io_reset),
            .tick   (tick),
            .pin_raw(io_pins_raw[i]),
            .bypass (io_bypass[i]),
            .level  (io_pins_read[i]),
            .rise   (io_rise[i]),
            .fall   (io_fall[i])
        );
    end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: two configurations checked every cycle against a
// per-pin consecutive-tick model, plus directed literal scenarios.
module tb_gpio_input_conditioner;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] raw_a, byp_a, pins_read_a, rise_a, fall_a;
    logic [7:0]  raw_b, byp_b, pins_read_b, rise_b, fall_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gpio_input_conditioner #(
        .WIDTH(32), .SYNC_STAGES(S), .TICK_DIV(1), .DEBOUNCE_TICKS(4), .RESET_VALUE(32'h0000_00F0)
    ) u_dut_a (
        .io_clock(clk), .io_reset(rst), .io_pins_raw(raw_a), .io_bypass(byp_a),
        .io_pins_read(pins_read_a), .io_rise(rise_a), .io_fall(fall_a)
    );

    gpio_input_conditioner #(
        .WIDTH(8), .SYNC_STAGES(S), .TICK_DIV(10), .DEBOUNCE_TICKS(2), .RESET_VALUE(8'h00)
    ) u_dut_b (
        .io_clock(clk), .io_reset(rst), .io_pins_raw(raw_b), .io_bypass(byp_b),
        .io_pins_read(pins_read_b), .io_rise(rise_b), .io_fall(fall_b)
    );

    // Model: a pin adopts its synchronized level after DT consecutive mismatching ticks.
    int          m_td[2] = '{1, 10};
    int          m_dt[2] = '{4, 2};
    int          m_w[2]  = '{32, 8};
    logic [31:0] m_rv[2] = '{32'h0000_00F0, 32'h0};
    logic [31:0] m_hist[2][S];
    logic [31:0] m_stable[2], m_prev[2];
    int          m_cnt[2][32];
    int          m_pc[2];

    always @(posedge clk) begin
        logic [31:0] rin, bin;
        logic        tk, s;
        for (int c = 0; c < 2; c++) begin
            rin = (c == 0) ? raw_a : {24'h0, raw_b};
            bin = (c == 0) ? byp_a : {24'h0, byp_b};
            if (rst) begin
                for (int k = 0; k < S; k++) m_hist[c][k] = m_rv[c];
                m_stable[c] = m_rv[c];
                m_prev[c]   = m_rv[c];
                for (int i = 0; i < 32; i++) m_cnt[c][i] = 0;
                m_pc[c] = 0;
            end else begin
                tk = (m_pc[c] == m_td[c] - 1);
                m_pc[c] = tk ? 0 : m_pc[c] + 1;
                m_prev[c] = m_stable[c];
                for (int i = 0; i < m_w[c]; i++) begin
                    s = m_hist[c][S-1][i];
                    if (bin[i]) begin
                        m_stable[c][i] = s;
                        m_cnt[c][i]    = 0;
                    end else if (s == m_stable[c][i]) begin
                        m_cnt[c][i] = 0;
                    end else if (tk) begin
                        m_cnt[c][i]++;
                        if (m_cnt[c][i] == m_dt[c]) begin
                            m_stable[c][i] = s;
                            m_cnt[c][i]    = 0;
                        end
                    end
                end
                for (int k = S - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
                m_hist[c][0] = rin;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and compare both DUTs against the model.
    task automatic cycle();
        @(negedge clk);
        check("a_read", pins_read_a, m_stable[0]);
        check("a_rise", rise_a, m_stable[0] & ~m_prev[0]);
        check("a_fall", fall_a, ~m_stable[0] & m_prev[0]);
        check("b_read", {24'h0, pins_read_b}, m_stable[1] & 32'hFF);
        check("b_rise", {24'h0, rise_b}, m_stable[1] & ~m_prev[1] & 32'hFF);
        check("b_fall", {24'h0, fall_b}, ~m_stable[1] & m_prev[1] & 32'hFF);
    endtask

    function automatic logic byp_val(input int k);
        return logic'(((k - 1) / 3) % 2);
    endfunction

    initial begin
        int cnt_r, cnt_f, first, lat, ev;
        logic ex;
        rst   = 1'b1;
        raw_a = 32'h0000_00F0;
        byp_a = '0;
        raw_b = '0;
        byp_b = '0;
        repeat (3) cycle();
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            cycle();
            check("rst_read", pins_read_a, 32'h0000_00F0);
            check("rst_events", rise_a | fall_a, 32'h0);
        end

        // Clean rise on pin 0: visible after edge 6.
        raw_a[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cycle();
            check("p0_level", {31'h0, pins_read_a[0]}, (k >= 6) ? 32'd1 : 32'd0);
            check("p0_rise", {31'h0, rise_a[0]}, (k == 6) ? 32'd1 : 32'd0);
        end

        // Bounce on pin 3: high 3, low 1, high held.
        cnt_r = 0;
        first = 0;
        raw_a[3] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cycle();
            if (rise_a[3]) begin
                cnt_r++;
                if (first == 0) first = k;
            end
            raw_a[3] = (k + 1 == 4) ? 1'b0 : 1'b1;
        end
        check("p3_rise_count", cnt_r, 1);
        check("p3_rise_edge", first, 10);

        // Bypass on pin 7 with a toggling raw level.
        cnt_r = 0;
        cnt_f = 0;
        byp_a[7] = 1'b1;
        raw_a[7] = byp_val(1);
        for (int k = 1; k <= 18; k++) begin
            cycle();
            ex = (k >= 3) ? byp_val(k - 2) : 1'b1;
            check("p7_bypass_level", {31'h0, pins_read_a[7]}, {31'h0, ex});
            if (rise_a[7]) cnt_r++;
            if (fall_a[7]) cnt_f++;
            raw_a[7] = byp_val(k + 1);
        end
        check("p7_rise_count", cnt_r, 3);
        check("p7_fall_count", cnt_f, 3);
        raw_a[7] = 1'b1;
        repeat (4) cycle();
        byp_a[7] = 1'b0;
        repeat (6) cycle();

        // Config B: slow ticks, fall latency window and short-pulse rejection.
        raw_b[5] = 1'b1;
        repeat (40) cycle();
        check("b5_settled_high", {31'h0, pins_read_b[5]}, 32'd1);
        raw_b[5] = 1'b0;
        lat = 0;
        cnt_f = 0;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            if (fall_b[5]) begin
                cnt_f++;
                if (lat == 0) lat = k;
            end
        end
        check("b5_fall_count", cnt_f, 1);
        check("b5_fall_window", {31'h0, (lat >= 13 && lat <= 22)}, 32'd1);
        ev = 0;
        raw_b[5] = 1'b1;
        for (int k = 1; k <= 49; k++) begin
            cycle();
            if (rise_b[5] || fall_b[5]) ev++;
            if (k == 9) raw_b[5] = 1'b0;
        end
        check("b5_short_pulse_events", ev, 0);
        check("b5_short_pulse_level", {31'h0, pins_read_b[5]}, 32'd0);

        // Reset while pin 1 is pending with two ticks counted.
        raw_a = 32'h0000_00F0;
        repeat (10) cycle();
        raw_a[1] = 1'b1;
        repeat (4) cycle();
        check("p1_pending_level", pins_read_a, 32'h0000_00F0);
        rst = 1'b1;
        repeat (2) begin
            cycle();
            check("mid_rst_level", pins_read_a, 32'h0000_00F0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cycle();
            if (k == 1) check("post_rst_events", rise_a | fall_a, 32'h0);
            check("p1_restart_level", {31'h0, pins_read_a[1]}, (k >= 6) ? 32'd1 : 32'd0);
        end

        // Randomized bouncing inputs, bypass flips and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 32; i++) begin
                if ($urandom_range(0, 15) == 0)  raw_a[i] = ~raw_a[i];
                if ($urandom_range(0, 255) == 0) byp_a[i] = ~byp_a[i];
            end
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 47) == 0)  raw_b[i] = ~raw_b[i];
                if ($urandom_range(0, 399) == 0) byp_b[i] = ~byp_b[i];
            end
            rst = ($urandom_range(0, 999) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
